// File: rtl/lc3_core_hs.sv
// lc3_core_hs: multicycle LC-3 core on a single valid/ready memory port.
// Stops in HALT on the HALT trap vector or on an RTI/reserved opcode.
module lc3_core_hs #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [7:0]  HALT_VECTOR = 8'h25,
    parameter bit          LEA_SETS_CC = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        halted,
    output logic        illegal,
    output logic        retired,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_rdata
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM1, MEM2, HALT
    } state_t;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JSR = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_RTI = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_RES = 4'hD;
    localparam logic [3:0] OP_LEA = 4'hE;
    localparam logic [3:0] OP_TRP = 4'hF;

    state_t      state;
    logic        run;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] ea;
    logic [2:0]  nzp;
    logic [15:0] regs [8];

    logic [3:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [15:0] off6;
    logic [15:0] off9;
    logic [15:0] off11;
    logic [15:0] alu;
    logic        hs;
    logic        single;
    logic        last_mem;
    logic        store_phase;

    assign op    = ir[15:12];
    assign dr    = ir[11:9];
    assign sr1   = ir[8:6];
    assign src1  = regs[sr1];
    assign src2  = ir[5] ? {{11{ir[4]}}, ir[4:0]} : regs[ir[2:0]];
    assign off6  = {{10{ir[5]}}, ir[5:0]};
    assign off9  = {{7{ir[8]}}, ir[8:0]};
    assign off11 = {{5{ir[10]}}, ir[10:0]};

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    always_comb begin
        alu = 16'h0000;
        case (op)
            OP_ADD:  alu = src1 + src2;
            OP_AND:  alu = src1 & src2;
            OP_NOT:  alu = ~src1;
            OP_LEA:  alu = pc + off9;
            default: alu = 16'h0000;
        endcase
    end

    assign single = op inside {OP_BR, OP_ADD, OP_AND, OP_NOT,
                               OP_LEA, OP_JMP, OP_JSR};
    assign last_mem = (state == MEM2) ||
                      (state == MEM1 && !(op inside {OP_LDI, OP_STI}));
    assign store_phase = (state == MEM1 && op inside {OP_ST, OP_STR}) ||
                         (state == MEM2 && op == OP_STI);

    // run keeps the bus quiet in the reset cycle even though state is FETCH
    assign mem_req   = run && (state inside {FETCH, MEM1, MEM2});
    assign hs        = mem_req && mem_ready;
    assign mem_we    = mem_req && store_phase;
    assign mem_addr  = !mem_req ? 16'h0000 : (state == FETCH ? pc : ea);
    assign mem_wdata = mem_we ? regs[dr] : 16'h0000;
    assign retired   = (state == EXEC && single) || (hs && last_mem);
    assign dbg_rdata = regs[dbg_sel];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            ir      <= 16'h0000;
            ea      <= 16'h0000;
            nzp     <= 3'b010;
            halted  <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else begin
            run <= 1'b1;
            case (state)
                FETCH: if (hs) begin
                    ir    <= mem_rdata;
                    pc    <= pc + 16'd1;
                    state <= DECODE;
                end
                DECODE: if (op == OP_RTI || op == OP_RES) begin
                    illegal <= 1'b1;
                    halted  <= 1'b1;
                    state   <= HALT;
                end else begin
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: begin
                            regs[dr] <= alu;
                            nzp      <= cc_of(alu);
                        end
                        OP_LEA: begin
                            regs[dr] <= alu;
                            if (LEA_SETS_CC) nzp <= cc_of(alu);
                        end
                        OP_BR: if ((dr & nzp) != 3'b000) pc <= pc + off9;
                        OP_JMP: pc <= src1;
                        OP_JSR: begin
                            // src1 is the pre-write R7, so JSRR R7 is safe
                            regs[7] <= pc;
                            pc      <= ir[11] ? pc + off11 : src1;
                        end
                        OP_LD, OP_ST, OP_LDI, OP_STI: begin
                            ea    <= pc + off9;
                            state <= MEM1;
                        end
                        OP_LDR, OP_STR: begin
                            ea    <= src1 + off6;
                            state <= MEM1;
                        end
                        OP_TRP: if (ir[7:0] == HALT_VECTOR) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            regs[7] <= pc;
                            ea      <= {8'h00, ir[7:0]};
                            state   <= MEM1;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM1: if (hs) begin
                    state <= FETCH;
                    case (op)
                        OP_LD, OP_LDR: begin
                            regs[dr] <= mem_rdata;
                            nzp      <= cc_of(mem_rdata);
                        end
                        OP_LDI, OP_STI: begin
                            ea    <= mem_rdata;
                            state <= MEM2;
                        end
                        OP_TRP: pc <= mem_rdata;
                        default: state <= FETCH;
                    endcase
                end
                MEM2: if (hs) begin
                    state <= FETCH;
                    if (op == OP_LDI) begin
                        regs[dr] <= mem_rdata;
                        nzp      <= cc_of(mem_rdata);
                    end
                end
                HALT: state <= HALT;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_core_hs.sv
// Bench for lc3_core_hs: ISA-level reference model driving a bus/retire
// checker, plus directed programs with hand-computed register results.
module tb_lc3_core_hs;
    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [15:0] d;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        halted;
    logic        illegal;
    logic        retired;
    logic [2:0]  dbg_sel = 3'd0;
    logic [15:0] dbg_rdata;

    logic [15:0] mem [65536];
    logic [15:0] mm [65536];
    int vecs = 0;
    int miss = 0;
    int wait_n = 0;
    int wcnt = 0;
    int writes = 0;
    logic hs_q = 1'b0;
    logic req_q = 1'b0;
    logic we_q = 1'b0;
    logic [15:0] addr_q = 16'h0000;
    logic [15:0] wd_q = 16'h0000;

    logic [15:0] m_pc;
    logic [15:0] m_r [8];
    logic [2:0]  m_nzp;
    logic m_halt = 1'b0;
    logic m_ill = 1'b0;
    logic halt_instr = 1'b0;
    logic active = 1'b0;
    acc_t exp_q [$];
    int exp_lat = 0;
    int cyc = 0;
    int retires = 0;
    int first_lat = 0;

    lc3_core_hs dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .halted(halted), .illegal(illegal), .retired(retired),
        .dbg_sel(dbg_sel), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Memory with wait_n ready-low cycles at the start of every access
    always @(negedge clk) begin
        mem_ready = mem_req && (wcnt >= wait_n);
        mem_rdata = mem[mem_addr];
    end

    always @(posedge clk) begin
        if (reset && hs_q) begin
            if (we_q) begin
                mem[addr_q] = wd_q;
                writes++;
            end
            wcnt = 0;
        end else if (reset && req_q) begin
            wcnt++;
        end
        hs_q = 1'b0;
        req_q = 1'b0;
    end

    function automatic logic [15:0] sx(input logic [15:0] x, input int n);
        int m;
        int v;
        m = 1 << n;
        v = int'(x) % m;
        if (v >= m / 2) v -= m;
        return 16'(v);
    endfunction

    function automatic logic [15:0] opnd(input logic [15:0] ir);
        return ir[5] ? sx(ir, 5) : m_r[ir[2:0]];
    endfunction

    task automatic setr(input logic [2:0] d, input logic [15:0] v);
        m_r[d] = v;
        if (v[15]) m_nzp = 3'b100;
        else if (v == 16'h0000) m_nzp = 3'b010;
        else m_nzp = 3'b001;
    endtask

    task automatic push(input logic [15:0] a, input logic w, input logic [15:0] d);
        acc_t e;
        e.a = a;
        e.we = w;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // One LC-3 instruction, producing its expected bus accesses in order
    task automatic model_step();
        logic [15:0] ir;
        logic [15:0] ad;
        logic [15:0] ptr;
        logic [15:0] t;
        int nd;
        nd = 0;
        ir = mm[m_pc];
        push(m_pc, 1'b0, 16'h0000);
        m_pc = m_pc + 16'd1;
        halt_instr = 1'b0;
        case (ir[15:12])
            4'h0: if ((ir[11:9] & m_nzp) != 3'b000) m_pc = m_pc + sx(ir, 9);
            4'h1: setr(ir[11:9], m_r[ir[8:6]] + opnd(ir));
            4'h5: setr(ir[11:9], m_r[ir[8:6]] & opnd(ir));
            4'h9: setr(ir[11:9], ~m_r[ir[8:6]]);
            4'hE: setr(ir[11:9], m_pc + sx(ir, 9));
            4'hC: m_pc = m_r[ir[8:6]];
            4'h4: begin
                t = ir[11] ? m_pc + sx(ir, 11) : m_r[ir[8:6]];
                m_r[7] = m_pc;
                m_pc = t;
            end
            4'h2, 4'h6: begin
                ad = (ir[15:12] == 4'h2) ? m_pc + sx(ir, 9)
                                         : m_r[ir[8:6]] + sx(ir, 6);
                push(ad, 1'b0, 16'h0000);
                setr(ir[11:9], mm[ad]);
                nd = 1;
            end
            4'h3, 4'h7: begin
                ad = (ir[15:12] == 4'h3) ? m_pc + sx(ir, 9)
                                         : m_r[ir[8:6]] + sx(ir, 6);
                push(ad, 1'b1, m_r[ir[11:9]]);
                mm[ad] = m_r[ir[11:9]];
                nd = 1;
            end
            4'hA: begin
                ad = m_pc + sx(ir, 9);
                ptr = mm[ad];
                push(ad, 1'b0, 16'h0000);
                push(ptr, 1'b0, 16'h0000);
                setr(ir[11:9], mm[ptr]);
                nd = 2;
            end
            4'hB: begin
                ad = m_pc + sx(ir, 9);
                ptr = mm[ad];
                push(ad, 1'b0, 16'h0000);
                push(ptr, 1'b1, m_r[ir[11:9]]);
                mm[ptr] = m_r[ir[11:9]];
                nd = 2;
            end
            4'hF: if (ir[7:0] == 8'h25) begin
                halt_instr = 1'b1;
                m_halt = 1'b1;
            end else begin
                m_r[7] = m_pc;
                ad = {8'h00, ir[7:0]};
                push(ad, 1'b0, 16'h0000);
                m_pc = mm[ad];
                nd = 1;
            end
            default: begin
                halt_instr = 1'b1;
                m_halt = 1'b1;
                m_ill = 1'b1;
            end
        endcase
        exp_lat = 3 + nd + (1 + nd) * wait_n;
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            vecs++;
            if ({mem_req, mem_we, halted, illegal, retired} != 5'b0 ||
                mem_addr != 16'h0000 || mem_wdata != 16'h0000) begin
                miss++;
                $display("FAIL reset_outs: req=%b we=%b addr=%h wd=%h halt=%b ill=%b ret=%b, required all 0",
                         mem_req, mem_we, mem_addr, mem_wdata, halted, illegal, retired);
            end
            exp_q.delete();
            active = 1'b0;
            cyc = 0;
        end else begin
            if (!active) begin
                model_step();
                active = 1'b1;
            end
            cyc++;
            if (mem_req) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miss++;
                    $display("FAIL bus_extra: req at addr=%h we=%b, required no request", mem_addr, mem_we);
                end else if (mem_addr != exp_q[0].a || mem_we != exp_q[0].we ||
                             (exp_q[0].we && mem_wdata != exp_q[0].d)) begin
                    miss++;
                    $display("FAIL bus: addr=%h we=%b wd=%h, required addr=%h we=%b wd=%h",
                             mem_addr, mem_we, mem_wdata, exp_q[0].a, exp_q[0].we, exp_q[0].d);
                end
                if (mem_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            hs_q = mem_req && mem_ready;
            req_q = mem_req;
            we_q = mem_we;
            addr_q = mem_addr;
            wd_q = mem_wdata;
            if (retired) begin
                vecs++;
                if (halt_instr || exp_q.size() != 0 || cyc != exp_lat) begin
                    miss++;
                    $display("FAIL retire: cycles=%0d pending=%0d halt_instr=%b, required cycles=%0d pending=0 halt_instr=0",
                             cyc, exp_q.size(), halt_instr, exp_lat);
                end
                if (retires == 0) first_lat = cyc;
                retires++;
                active = 1'b0;
                cyc = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        vecs++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic start(input int wn);
        @(negedge clk);
        #3;
        reset = 1'b0;
        wait_n = wn;
        wcnt = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'h0000;
            mm[i] = 16'h0000;
        end
        m_pc = 16'h0000;
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        m_nzp = 3'b010;
        m_halt = 1'b0;
        m_ill = 1'b0;
        halt_instr = 1'b0;
        retires = 0;
        first_lat = 0;
        writes = 0;
    endtask

    task automatic ld(input logic [15:0] a, input logic [15:0] d);
        mem[a] = d;
        mm[a] = d;
    endtask

    task automatic go();
        @(negedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic finish_prog(input string nm);
        int n;
        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (!halted) begin
            miss++;
            $display("FAIL %s_timeout: halted=0 after %0d cycles, required 1", nm, n);
        end
        repeat (4) @(negedge clk);
        #3;
        chk({nm, "_req_idle"}, 16'(mem_req), 16'h0000);
        chk({nm, "_halted"}, 16'(halted), 16'(m_halt));
        chk({nm, "_illegal"}, 16'(illegal), 16'(m_ill));
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", nm, i), dbg_rdata, m_r[i]);
        end
    endtask

    task automatic rd(input logic [2:0] r, output logic [15:0] v);
        dbg_sel = r;
        #1;
        v = dbg_rdata;
    endtask

    initial begin
        logic [15:0] v;
        int n;

        // ADD then BRp on the resulting P flag
        start(0);
        ld(16'h0, 16'h1021); ld(16'h1, 16'h0201); ld(16'h2, 16'hF025);
        ld(16'h3, 16'h1021); ld(16'h4, 16'hF025);
        go();
        finish_prog("add");
        chk("add_first_lat", 16'(first_lat), 16'd3);
        rd(3'd0, v); chk("add_r0", v, 16'h0002);
        chk("add_retires", 16'(retires), 16'd3);
        chk("add_illegal", 16'(illegal), 16'h0000);

        // LD with two wait cycles per access, then BRn
        start(2);
        ld(16'h0, 16'h2002); ld(16'h1, 16'h0802); ld(16'h2, 16'hF025);
        ld(16'h3, 16'h8000); ld(16'h4, 16'h1221); ld(16'h5, 16'hF025);
        go();
        finish_prog("ld");
        chk("ld_first_lat", 16'(first_lat), 16'd8);
        rd(3'd0, v); chk("ld_r0", v, 16'h8000);
        rd(3'd1, v); chk("ld_r1", v, 16'h8001);

        // LD/STI/LDI/STR/LDR through memory with one wait cycle
        start(1);
        ld(16'h0, 16'h2205); ld(16'h1, 16'hB205); ld(16'h2, 16'hA404);
        ld(16'h3, 16'h72D0); ld(16'h4, 16'h68D0); ld(16'h5, 16'hF025);
        ld(16'h6, 16'hABCD); ld(16'h7, 16'h0040);
        go();
        finish_prog("mem");
        chk("sti_target", mem[16'h0040], 16'hABCD);
        chk("str_target", mem[16'h0010], 16'hABCD);
        chk("mem_writes", 16'(writes), 16'd2);
        rd(3'd2, v); chk("ldi_r2", v, 16'hABCD);
        rd(3'd4, v); chk("ldr_r4", v, 16'hABCD);

        // LEA, BR, JSRR R7, JMP R7, JSR, RET, NOT
        start(0);
        ld(16'h0000, 16'hEEFF); ld(16'h0001, 16'h0E0E);
        ld(16'h0010, 16'h41C0); ld(16'h0100, 16'hC1C0);
        ld(16'h0011, 16'h4802); ld(16'h0014, 16'hC1C0);
        ld(16'h0012, 16'h91FF); ld(16'h0013, 16'hF025);
        go();
        finish_prog("jmp");
        rd(3'd7, v); chk("jmp_r7", v, 16'h0012);
        rd(3'd0, v); chk("not_r0", v, 16'hFFED);
        chk("jmp_retires", 16'(retires), 16'd7);

        // Vectored TRAP, then HALT trap leaves R7 alone
        start(1);
        ld(16'h0000, 16'hF030); ld(16'h0030, 16'h0200);
        ld(16'h0200, 16'h1FE5); ld(16'h0201, 16'hF025);
        go();
        finish_prog("trap");
        rd(3'd7, v); chk("trap_r7", v, 16'h0006);
        chk("trap_halted", 16'(halted), 16'h0001);
        chk("trap_retires", 16'(retires), 16'd2);

        // Reserved opcode after one ADD
        start(0);
        ld(16'h0, 16'h1021); ld(16'h1, 16'hD000);
        go();
        finish_prog("ill");
        chk("ill_illegal", 16'(illegal), 16'h0001);
        chk("ill_retires", 16'(retires), 16'd1);

        // Reset while a store is stalled on ready
        start(50);
        ld(16'h0, 16'h1021); ld(16'h1, 16'h3005); ld(16'h7, 16'h1234);
        go();
        n = 0;
        while (!mem_we && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("st_seen", 16'(mem_we), 16'h0001);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_req_drop", 16'(mem_req), 16'h0000);
        chk("rst_we_drop", 16'(mem_we), 16'h0000);
        rd(3'd0, v); chk("rst_r0", v, 16'h0000);
        repeat (2) @(negedge clk);
        #3;
        chk("st_abandoned", mem[16'h0007], 16'h1234);
        chk("st_no_writes", 16'(writes), 16'd0);
        start(0);
        ld(16'h0, 16'h0402); ld(16'h1, 16'h1021);
        ld(16'h2, 16'hF025); ld(16'h3, 16'hF025);
        go();
        finish_prog("rst");
        rd(3'd0, v); chk("rst_brz_r0", v, 16'h0000);
        chk("rst_retires", 16'(retires), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
